// File: rtl/cep_dct_ctrl.sv
// cep_dct_ctrl: nested-loop sequencer for the cepstral DCT stage.
// Outer loop walks cepstral coefficients; inner loop issues MAC enables and addresses per mel bin.
module cep_dct_ctrl #(
    parameter int IDX_WIDTH  = 6,
    parameter int ADDR_WIDTH = 12,
    parameter int MAC_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [IDX_WIDTH-1:0]  num_cep_i,
    input  logic [IDX_WIDTH-1:0]  num_mel_i,
    input  logic                  out_ready_i,
    output logic                  busy_o,
    output logic                  acc_clr_o,
    output logic                  mac_en_o,
    output logic [IDX_WIDTH-1:0]  mel_addr_o,
    output logic [ADDR_WIDTH-1:0] coef_addr_o,
    output logic [IDX_WIDTH-1:0]  cep_idx_o,
    output logic                  cep_valid_o,
    output logic                  done_o
);
    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {IDLE, CLR, MAC, DRAIN, OUT, DONE} state_e;

    state_e                state_q, state_d;
    logic [IDX_WIDTH-1:0]  num_cep_q, num_cep_d;
    logic [IDX_WIDTH-1:0]  num_mel_q, num_mel_d;
    logic [IDX_WIDTH-1:0]  mel_addr_q, mel_addr_d;
    logic [ADDR_WIDTH-1:0] coef_addr_q, coef_addr_d;
    logic [IDX_WIDTH-1:0]  cep_idx_q, cep_idx_d;
    logic [DW-1:0]         drn_q, drn_d;
    logic                  ack_q, ack_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            num_cep_q   <= '0;
            num_mel_q   <= '0;
            mel_addr_q  <= '0;
            coef_addr_q <= '0;
            cep_idx_q   <= '0;
            drn_q       <= '0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_cep_q   <= num_cep_d;
            num_mel_q   <= num_mel_d;
            mel_addr_q  <= mel_addr_d;
            coef_addr_q <= coef_addr_d;
            cep_idx_q   <= cep_idx_d;
            drn_q       <= drn_d;
            ack_q       <= ack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        num_cep_d   = num_cep_q;
        num_mel_d   = num_mel_q;
        mel_addr_d  = mel_addr_q;
        coef_addr_d = coef_addr_q;
        cep_idx_d   = cep_idx_q;
        drn_d       = drn_q;
        ack_d       = ack_q;
        case (state_q)
            IDLE: if (start_i) begin
                num_cep_d   = num_cep_i;
                num_mel_d   = num_mel_i;
                cep_idx_d   = '0;
                coef_addr_d = '0;
                mel_addr_d  = '0;
                state_d     = CLR;
            end
            CLR: state_d = MAC;
            MAC: begin
                coef_addr_d = coef_addr_q + 1'b1;
                if (mel_addr_q == num_mel_q) begin
                    drn_d   = '0;
                    state_d = DRAIN;
                end else begin
                    mel_addr_d = mel_addr_q + 1'b1;
                end
            end
            DRAIN: begin
                drn_d = drn_q + 1'b1;
                if (drn_q == DW'(MAC_LAT - 1)) state_d = OUT;
            end
            // Handshake is registered into ack_q; the following cycle is the turnaround.
            OUT: if (ack_q) begin
                ack_d = 1'b0;
                if (cep_idx_q == num_cep_q) begin
                    state_d = DONE;
                end else begin
                    cep_idx_d  = cep_idx_q + 1'b1;
                    mel_addr_d = '0;
                    state_d    = CLR;
                end
            end else if (out_ready_i) begin
                ack_d = 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o      = state_q != IDLE;
    assign acc_clr_o   = state_q == CLR;
    assign mac_en_o    = state_q == MAC;
    assign cep_valid_o = (state_q == OUT) && !ack_q;
    assign done_o      = state_q == DONE;
    assign mel_addr_o  = mel_addr_q;
    assign coef_addr_o = coef_addr_q;
    assign cep_idx_o   = cep_idx_q;
endmodule

// File: tb/tb_cep_dct_ctrl.sv
// tb_cep_dct_ctrl: scoreboard bench for cep_dct_ctrl.
// Stimulus pushes expected MAC addresses, coefficient indices and frame lengths; monitors pop and compare.
module tb_cep_dct_ctrl;
    localparam int IW  = 6;
    localparam int AW  = 12;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0, out_ready = 1'b1;
    logic [IW-1:0] num_cep = '0, num_mel = '0;
    logic          busy, acc_clr, mac_en, cep_valid, done;
    logic [IW-1:0] mel_addr, cep_idx;
    logic [AW-1:0] coef_addr;

    logic          w_start = 1'b0, w_ready = 1'b1;
    logic [IW-1:0] w_num_cep = '0, w_num_mel = '0;
    logic          w_busy, w_acc_clr, w_mac_en, w_cep_valid, w_done;
    logic [IW-1:0] w_mel_addr, w_cep_idx;
    logic [3:0]    w_coef_addr;

    cep_dct_ctrl #(.IDX_WIDTH(IW), .ADDR_WIDTH(AW), .MAC_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .num_cep_i(num_cep), .num_mel_i(num_mel),
        .out_ready_i(out_ready), .busy_o(busy), .acc_clr_o(acc_clr), .mac_en_o(mac_en),
        .mel_addr_o(mel_addr), .coef_addr_o(coef_addr), .cep_idx_o(cep_idx),
        .cep_valid_o(cep_valid), .done_o(done)
    );

    cep_dct_ctrl #(.IDX_WIDTH(IW), .ADDR_WIDTH(4), .MAC_LAT(LAT)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start_i(w_start), .num_cep_i(w_num_cep), .num_mel_i(w_num_mel),
        .out_ready_i(w_ready), .busy_o(w_busy), .acc_clr_o(w_acc_clr), .mac_en_o(w_mac_en),
        .mel_addr_o(w_mel_addr), .coef_addr_o(w_coef_addr), .cep_idx_o(w_cep_idx),
        .cep_valid_o(w_cep_valid), .done_o(w_done)
    );

    int checks = 0, failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mac_q[$], w_mac_q[$];
    int          out_q[$], len_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pack(input int c, input int m, input int a);
        return {8'(c), 8'(m), 16'(a)};
    endfunction

    task automatic expect_frame(input int nc, input int nm, input int stall, input int mask, input bit wrap);
        int a = 0;
        for (int c = 0; c <= nc; c++) begin
            for (int m = 0; m <= nm; m++) begin
                if (wrap) w_mac_q.push_back(pack(c, m, a & mask));
                else mac_q.push_back(pack(c, m, a & mask));
                a++;
            end
            if (!wrap) out_q.push_back(c);
        end
        if (!wrap) len_q.push_back((nc + 1) * (nm + 4 + LAT) + stall);
    endtask

    task automatic pulse_start(input int nc, input int nm);
        num_cep = IW'(nc);
        num_mel = IW'(nm);
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 3000) begin
            @(posedge clk) #1;
            n++;
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        @(posedge clk) #1;
        chk({name, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    // Main-DUT monitor: MAC address stream, output handshakes, hold under backpressure, frame length.
    initial begin
        bit          in_frame = 0, hold = 0;
        int          clr_cyc = 0;
        logic [IW-1:0] hold_idx = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 0;
                hold = 0;
            end else begin
                if (acc_clr && !in_frame) begin
                    in_frame = 1;
                    clr_cyc = cyc;
                end
                if (mac_en) begin
                    if (mac_q.size() == 0) chk("mac_unexpected", 32'd1, 32'd0);
                    else chk("mac_addr", pack(int'(cep_idx), int'(mel_addr), int'(coef_addr)), mac_q.pop_front());
                end
                if (hold) chk("bp_hold", {23'd0, cep_valid, 8'(cep_idx)}, {23'd0, 1'b1, 8'(hold_idx)});
                if (cep_valid) chk("valid_excl", {28'd0, mac_en, acc_clr, done, busy}, 32'd1);
                if (cep_valid && out_ready) begin
                    if (out_q.size() == 0) chk("out_unexpected", 32'd1, 32'd0);
                    else chk("cep_idx", 32'(cep_idx), 32'(out_q.pop_front()));
                end
                hold = cep_valid && !out_ready;
                hold_idx = cep_idx;
                if (done) begin
                    if (len_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
                    else chk("frame_len", 32'(cyc - clr_cyc), 32'(len_q.pop_front()));
                    in_frame = 0;
                end
            end
        end
    end

    // Wrap-DUT monitor: 4-bit coefficient address stream.
    initial forever begin
        @(negedge clk);
        if (rst_n && w_mac_en) begin
            if (w_mac_q.size() == 0) chk("wrap_unexpected", 32'd1, 32'd0);
            else chk("wrap_addr", pack(int'(w_cep_idx), int'(w_mel_addr), int'(w_coef_addr)), w_mac_q.pop_front());
        end
    end

    initial begin
        int n;
        #1;
        chk("reset_outs", {busy, acc_clr, mac_en, mel_addr, coef_addr, cep_idx, cep_valid, done}, 32'd0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(posedge clk) #1;

        // Minimal frame with start-to-valid latency
        expect_frame(0, 0, 0, 4095, 0);
        pulse_start(0, 0);
        n = 0;
        while (!cep_valid && n < 100) begin
            @(posedge clk) #1;
            n++;
        end
        chk("latency", 32'(n), 32'(2 + LAT));
        wait_done("minimal");

        // Nominal frame
        expect_frame(12, 25, 0, 4095, 0);
        pulse_start(12, 25);
        wait_done("nominal");
        chk("final_coef", 32'(coef_addr), 32'd338);

        // Backpressure on cep_idx 3
        expect_frame(5, 4, 5, 4095, 0);
        pulse_start(5, 4);
        fork
            wait_done("backpressure");
            begin
                int k = 0;
                while (!(cep_valid && cep_idx == 3) && k < 1000) begin
                    @(posedge clk) #1;
                    k++;
                end
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join

        // Start pulses during MAC and OUT are ignored
        expect_frame(2, 4, 0, 4095, 0);
        pulse_start(2, 4);
        fork
            wait_done("ignored_start");
            begin
                int k = 0;
                while (!mac_en && k < 100) begin
                    @(posedge clk) #1;
                    k++;
                end
                pulse_start(5, 3);
                k = 0;
                while (!cep_valid && k < 100) begin
                    @(posedge clk) #1;
                    k++;
                end
                pulse_start(7, 7);
            end
        join

        // Asynchronous reset in the middle of MAC, then a clean frame
        expect_frame(3, 7, 0, 4095, 0);
        pulse_start(3, 7);
        n = 0;
        while (!(mac_en && cep_idx == 1) && n < 200) begin
            @(posedge clk) #1;
            n++;
        end
        chk("pre_reset_mac", 32'(mac_en), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", {busy, acc_clr, mac_en, mel_addr, coef_addr, cep_idx, cep_valid, done}, 32'd0);
        mac_q.delete();
        out_q.delete();
        len_q.delete();
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(posedge clk) #1;
        expect_frame(1, 3, 0, 4095, 0);
        pulse_start(1, 3);
        wait_done("post_reset");

        // Address wrap on the 4-bit ROM instance
        expect_frame(1, 9, 0, 15, 1);
        w_num_cep = 6'd1;
        w_num_mel = 6'd9;
        w_start = 1'b1;
        @(posedge clk) #1;
        w_start = 1'b0;
        n = 0;
        while (!w_done && n < 200) begin
            @(posedge clk) #1;
            n++;
        end
        chk("wrap_done", 32'(w_done), 32'd1);
        chk("wrap_len", 32'(n), 32'(2 * (9 + 4 + LAT)));

        repeat (3) @(posedge clk);
        chk("mac_q_empty", 32'(mac_q.size()), 32'd0);
        chk("out_q_empty", 32'(out_q.size()), 32'd0);
        chk("len_q_empty", 32'(len_q.size()), 32'd0);
        chk("wrap_q_empty", 32'(w_mac_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cep_dct_ctrl.md
# cep_dct_ctrl

Sequencing controller for the cepstral DCT stage of the MFCC pipeline. It drives the nested loop over cepstral coefficients (outer) and mel filter bins (inner). For each coefficient it issues accumulator-clear, per-bin MAC enables and addresses, then a drain delay. It then presents the coefficient index to the downstream cepstral stage with a valid/ready handshake. It sits between the log-mel buffer / DCT coefficient ROM and the cepstral loop counter and lifter stage.

## Interface
Parameters:
- IDX_WIDTH, 6, width of cepstral and mel index buses
- ADDR_WIDTH, 12, width of DCT coefficient ROM address
- MAC_LAT, 2, pipeline latency of external MAC (drain cycles, ≥1)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin one frame; sampled only in IDLE
- num_cep  input  IDX_WIDTH  last cepstral index (count = num_cep+1); latched at start
- num_mel  input  IDX_WIDTH  last mel bin index (count = num_mel+1); latched at start
- out_ready  input  1  downstream accepts current coefficient
- busy  output  1  high in every state except IDLE
- acc_clr  output  1  clear external accumulator (one cycle per coefficient)
- mac_en  output  1  external MAC accumulates this cycle
- mel_addr  output  IDX_WIDTH  log-mel buffer read address
- coef_addr  output  ADDR_WIDTH  DCT ROM address
- cep_idx  output  IDX_WIDTH  current cepstral coefficient index
- cep_valid  output  1  accumulator result for cep_idx is final
- done  output  1  one-cycle pulse after last coefficient accepted

## Operation
- States: IDLE, CLR, MAC, DRAIN, OUT, DONE. Reset → IDLE.
- IDLE: start=1 → latch num_cep/num_mel, cep_idx=0, coef_addr=0 → CLR.
- CLR: acc_clr=1 for one cycle, mel_addr=0 → MAC.
- MAC: mac_en=1 every cycle. mel_addr and coef_addr each +1 per cycle. When mel_addr==num_mel_q (last bin issued), go to DRAIN and hold mel_addr.
- DRAIN: count MAC_LAT cycles, mac_en=0 → OUT.
- OUT: cep_valid=1, cep_idx stable. out_ready=1 completes the transfer. If cep_idx==num_cep_q → DONE, else cep_idx+1 → CLR. coef_addr continues from its current value, giving row-major ROM layout.
- DONE: done=1 for one cycle → IDLE.
- coef_addr wraps modulo 2^ADDR_WIDTH. No saturation. Overflow is the ROM sizer's responsibility.
- start in any state other than IDLE is ignored. num_cep/num_mel changes after latch are ignored.
- num_mel=0 means a single MAC cycle. num_cep=0 means a single coefficient.
- out_ready outside OUT has no effect. cep_valid never drops without handshake.
- rst_n low at any time: immediate return to IDLE with all outputs at reset values, mid-frame included.

## Timing
- Reset values: busy=0, acc_clr=0, mac_en=0, mel_addr=0, coef_addr=0, cep_idx=0, cep_valid=0, done=0.
- All outputs registered or decoded from registered state only; no combinational path from out_ready to any output.
- start sampled in cycle t → CLR in t+1 → MAC in t+2 … t+2+num_mel → DRAIN for MAC_LAT cycles → cep_valid first high at t+3+num_mel+MAC_LAT.
- Per coefficient with out_ready held high: (num_mel+1) + MAC_LAT + 3 cycles (CLR + OUT + handshake turnaround into CLR).
- Frame with out_ready constantly high: (num_cep+1)·(num_mel+4+MAC_LAT) cycles from CLR entry to DONE entry, plus 1 cycle for done.
- busy rises the cycle after start is sampled and falls the cycle after done.

## Test plan
- Reset mid-MAC: assert rst_n=0 while mac_en=1 → all outputs 0 asynchronously, IDLE. A subsequent start runs a clean frame from cep_idx=0, coef_addr=0.
- Nominal: num_cep=12, num_mel=25, MAC_LAT=2, out_ready=1 → 13 cep_valid pulses with cep_idx 0..12 and 26 mac_en cycles per coefficient. Final coef_addr=338. done exactly once, 404 cycles from CLR entry.
- Backpressure: out_ready=0 for 5 cycles on cep_idx=3 → cep_valid and cep_idx=3 held stable, no mac_en/acc_clr. Resumes with CLR the cycle after ready.
- Minimal sizes: num_cep=0, num_mel=0 → one acc_clr, one mac_en at mel_addr=0/coef_addr=0, one cep_valid, done.
- Ignored start: pulse start during MAC and OUT with different num_cep/num_mel → frame length unchanged, no restart.
- Address wrap: ADDR_WIDTH=4, num_cep=1, num_mel=9 → coef_addr sequence 0..9 then 10..15,0..3. No stall.
